// File: rtl/posit_defines.sv
// posit_defines: quire beat layout, quire result width and arbiter FSM encoding.
package posit_defines;

    localparam int QUIRE_SIZE = 19;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    typedef struct packed {
        logic [3:0]        fraction;
        logic signed [3:0] scale;
        logic              sign;
        logic              zero;
        logic              NaR;
        logic              sow;
        logic              eow;
    } quire_beat_t;

endpackage

// File: rtl/quire_window_arbiter_tag_fifo.sv
// tag_fifo: owner-tag FIFO with full/empty flags; pointers wrap at DEPTH.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          push_ok, pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk)
        if (push_ok) mem[wptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
            if (pop_ok) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter: round-robin window-atomic sharing of one quire, with owner tags routing results back.
module quire_window_arbiter
    import posit_defines::*;
#(
    parameter int NB_REQ    = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NB_REQ-1:0]     req_rts_i,
    output logic [NB_REQ-1:0]     req_rtr_o,
    input  logic [NB_REQ-1:0]     req_sow_i,
    input  logic [NB_REQ-1:0]     req_eow_i,
    input  logic [NB_REQ-1:0]     req_sign_i,
    input  logic [NB_REQ-1:0]     req_zero_i,
    input  logic [NB_REQ-1:0]     req_NaR_i,
    input  logic [NB_REQ*4-1:0]   req_fraction_i,
    input  logic [NB_REQ*4-1:0]   req_scale_i,
    output logic                  q_rts_o,
    input  logic                  q_rtr_i,
    output logic                  q_sow_o,
    output logic                  q_eow_o,
    output logic                  q_sign_o,
    output logic                  q_zero_o,
    output logic                  q_NaR_o,
    output logic [3:0]            q_fraction_o,
    output logic signed [3:0]     q_scale_o,
    input  logic                  res_rts_i,
    output logic                  res_rtr_o,
    input  logic                  res_eow_i,
    input  logic                  res_NaR_i,
    input  logic                  res_zero_i,
    input  logic [QUIRE_SIZE-1:0] res_data_i,
    output logic                  out_rts_o,
    input  logic                  out_rtr_i,
    output logic [QUIRE_SIZE-1:0] out_data_o,
    output logic [ID_W-1:0]       out_id_o,
    output logic                  out_NaR_o,
    output logic                  out_zero_o,
    output logic                  err_o
);
    logic [0:0]        state;
    logic [ID_W-1:0]   owner, rr_ptr, win, idx;
    logic [NB_REQ-1:0] elig;
    logic              first, grant, q_hs, tag_full, tag_empty, pop, res_orphan;
    quire_beat_t       beat;

    assign elig = req_rts_i & req_sow_i;

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        win = rr_ptr;
        idx = rr_ptr;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            idx = rr_ptr + ID_W'(i);
            if (elig[idx]) win = idx;
        end
    end

    assign grant = (state == IDLE) & (|elig) & ~tag_full;

    assign beat = '{
        fraction: req_fraction_i[int'(owner)*4 +: 4],
        scale:    req_scale_i[int'(owner)*4 +: 4],
        sign:     req_sign_i[owner],
        zero:     req_zero_i[owner],
        NaR:      req_NaR_i[owner],
        sow:      req_sow_i[owner],
        eow:      req_eow_i[owner]
    };

    assign q_rts_o      = (state == LOCKED) & req_rts_i[owner];
    assign req_rtr_o    = (state == LOCKED) ? (NB_REQ'(q_rtr_i) << owner) : '0;
    assign q_fraction_o = beat.fraction;
    assign q_scale_o    = beat.scale;
    assign q_sign_o     = beat.sign;
    assign q_zero_o     = beat.zero;
    assign q_NaR_o      = beat.NaR;
    assign q_sow_o      = beat.sow;
    assign q_eow_o      = beat.eow;
    assign q_hs         = q_rts_o & q_rtr_i;

    // Non-final result beats are swallowed; orphan eow beats are swallowed and flagged.
    assign res_orphan = res_rts_i & res_eow_i & tag_empty;
    assign out_rts_o  = res_rts_i & res_eow_i & ~tag_empty;
    assign res_rtr_o  = ~res_eow_i | tag_empty | out_rtr_i;
    assign pop        = out_rts_o & out_rtr_i;
    assign out_data_o = res_data_i;
    assign out_NaR_o  = res_NaR_i;
    assign out_zero_o = res_zero_i;

    tag_fifo #(.DEPTH(TAG_DEPTH), .W(ID_W)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (pop),
        .din   (win),
        .dout  (out_id_o),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            first  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            if (grant) begin
                state <= LOCKED;
                owner <= win;
                first <= 1'b1;
            end else if (q_hs) begin
                first <= 1'b0;
                if (q_eow_o) begin
                    state  <= IDLE;
                    rr_ptr <= owner + ID_W'(1);
                end
            end
            if ((q_hs & q_sow_o & ~first) | res_orphan) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_quire_window_arbiter.sv
// tb_quire_window_arbiter: directed scenario tests for the quire window arbiter.
module tb_quire_window_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_rts, req_rtr, req_sow, req_eow, req_sign, req_zero, req_nar;
    logic [15:0] req_frac, req_scale;
    logic        q_rts, q_rtr, q_sow, q_eow, q_sign, q_zero, q_nar;
    logic [3:0]  q_frac;
    logic signed [3:0] q_scale;
    logic        res_rts, res_rtr, res_eow, res_nar, res_zero;
    logic [18:0] res_data, out_data;
    logic        out_rts, out_rtr, out_nar, out_zero, err;
    logic [1:0]  out_id;
    int          errors = 0;
    int          checks = 0;

    quire_window_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_rts_i(req_rts), .req_rtr_o(req_rtr), .req_sow_i(req_sow), .req_eow_i(req_eow),
        .req_sign_i(req_sign), .req_zero_i(req_zero), .req_NaR_i(req_nar),
        .req_fraction_i(req_frac), .req_scale_i(req_scale),
        .q_rts_o(q_rts), .q_rtr_i(q_rtr), .q_sow_o(q_sow), .q_eow_o(q_eow), .q_sign_o(q_sign),
        .q_zero_o(q_zero), .q_NaR_o(q_nar), .q_fraction_o(q_frac), .q_scale_o(q_scale),
        .res_rts_i(res_rts), .res_rtr_o(res_rtr), .res_eow_i(res_eow), .res_NaR_i(res_nar),
        .res_zero_i(res_zero), .res_data_i(res_data),
        .out_rts_o(out_rts), .out_rtr_i(out_rtr), .out_data_o(out_data), .out_id_o(out_id),
        .out_NaR_o(out_nar), .out_zero_o(out_zero), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic sow, input logic eow, input logic [3:0] frac);
        req_rts[id] = 1'b1;
        req_sow[id] = sow;
        req_eow[id] = eow;
        req_frac[id*4 +: 4] = frac;
    endtask

    task automatic clr_req(input int id);
        req_rts[id] = 1'b0;
        req_sow[id] = 1'b0;
        req_eow[id] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_rts = 4'hF; req_sow = 4'hF; req_eow = '0; req_sign = '0; req_zero = '0; req_nar = '0;
        req_frac = '0; req_scale = '0; q_rtr = 1'b1;
        res_rts = 1'b1; res_eow = 1'b1; res_nar = 1'b0; res_zero = 1'b0; res_data = '0; out_rtr = 1'b1;
        tick();
        tick();
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL reset_q_rts got=%0h exp=0", q_rts); end
        checks++; if (req_rtr !== 4'b0000) begin errors++; $display("FAIL reset_req_rtr got=%0h exp=0", req_rtr); end
        checks++; if (out_rts !== 1'b0) begin errors++; $display("FAIL reset_out_rts got=%0h exp=0", out_rts); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", err); end
        req_rts = '0; req_sow = '0; res_rts = 1'b0; res_eow = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_window();
        q_rtr = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'h1);
        req_scale[3:0] = 4'hA;
        req_sign[0] = 1'b1;
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL win_grant_q_rts got=%0h exp=0", q_rts); end
        checks++; if (req_rtr !== 4'b0000) begin errors++; $display("FAIL win_grant_rtr got=%0h exp=0", req_rtr); end
        tick();
        checks++; if (q_rts !== 1'b1) begin errors++; $display("FAIL win_b1_q_rts got=%0h exp=1", q_rts); end
        checks++; if (q_sow !== 1'b1) begin errors++; $display("FAIL win_b1_sow got=%0h exp=1", q_sow); end
        checks++; if (q_frac !== 4'h1) begin errors++; $display("FAIL win_b1_frac got=%0h exp=1", q_frac); end
        checks++; if (q_scale !== 4'hA) begin errors++; $display("FAIL win_b1_scale got=%0h exp=a", q_scale); end
        checks++; if (q_sign !== 1'b1) begin errors++; $display("FAIL win_b1_sign got=%0h exp=1", q_sign); end
        checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL win_b1_rtr got=%0h exp=1", req_rtr); end
        tick();
        set_req(0, 1'b0, 1'b0, 4'h2);
        req_sign[0] = 1'b0;
        q_rtr = 1'b0;
        #1;
        checks++; if (req_rtr !== 4'b0000) begin errors++; $display("FAIL win_stall_rtr got=%0h exp=0", req_rtr); end
        tick();
        q_rtr = 1'b1;
        #1;
        checks++; if (q_frac !== 4'h2) begin errors++; $display("FAIL win_b2_frac got=%0h exp=2", q_frac); end
        checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL win_b2_rtr got=%0h exp=1", req_rtr); end
        tick();
        set_req(0, 1'b0, 1'b1, 4'h3);
        #1;
        checks++; if (q_eow !== 1'b1 || q_frac !== 4'h3) begin errors++; $display("FAIL win_b3 got eow=%0h frac=%0h exp eow=1 frac=3", q_eow, q_frac); end
        tick();
        clr_req(0);
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL win_idle_q_rts got=%0h exp=0", q_rts); end
        res_rts = 1'b1; res_eow = 1'b0; out_rtr = 1'b1;
        #1;
        checks++; if (res_rtr !== 1'b1 || out_rts !== 1'b0) begin errors++; $display("FAIL win_partial_res got rtr=%0h out_rts=%0h exp rtr=1 out_rts=0", res_rtr, out_rts); end
        tick();
        res_eow = 1'b1; res_data = 19'h5A5A5; res_nar = 1'b1;
        #1;
        checks++; if (out_rts !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL win_result got rts=%0h id=%0d exp rts=1 id=0", out_rts, out_id); end
        checks++; if (out_data !== 19'h5A5A5 || out_nar !== 1'b1) begin errors++; $display("FAIL win_result_data got=%0h nar=%0h exp=5a5a5 nar=1", out_data, out_nar); end
        tick();
        res_rts = 1'b0; res_nar = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL win_err got=%0h exp=0", err); end
    endtask

    task automatic test_round_robin();
        set_req(1, 1'b1, 1'b1, 4'h4);
        tick();
        tick();
        clr_req(1);
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL rr_pre_id got=%0d exp=1", out_id); end
        tick();
        res_rts = 1'b0;
        set_req(1, 1'b1, 1'b1, 4'h5);
        set_req(3, 1'b1, 1'b0, 4'h6);
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL rr_grant_q_rts got=%0h exp=0", q_rts); end
        tick();
        checks++; if (req_rtr !== 4'b1000 || q_frac !== 4'h6) begin errors++; $display("FAIL rr_owner3 got rtr=%0h frac=%0h exp rtr=8 frac=6", req_rtr, q_frac); end
        tick();
        set_req(3, 1'b0, 1'b1, 4'h7);
        #1;
        checks++; if (req_rtr !== 4'b1000 || q_eow !== 1'b1) begin errors++; $display("FAIL rr_owner3_eow got rtr=%0h eow=%0h exp rtr=8 eow=1", req_rtr, q_eow); end
        tick();
        clr_req(3);
        #1;
        checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000) begin errors++; $display("FAIL rr_regrant_idle got rts=%0h rtr=%0h exp rts=0 rtr=0", q_rts, req_rtr); end
        tick();
        checks++; if (req_rtr !== 4'b0010 || q_frac !== 4'h5) begin errors++; $display("FAIL rr_owner1 got rtr=%0h frac=%0h exp rtr=2 frac=5", req_rtr, q_frac); end
        tick();
        clr_req(1);
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_id !== 2'd3) begin errors++; $display("FAIL rr_tag0 got=%0d exp=3", out_id); end
        tick();
        checks++; if (out_id !== 2'd1 || out_rts !== 1'b1) begin errors++; $display("FAIL rr_tag1 got id=%0d rts=%0h exp id=1 rts=1", out_id, out_rts); end
        tick();
        res_rts = 1'b0;
    endtask

    task automatic test_single_beat();
        set_req(2, 1'b1, 1'b1, 4'h8);
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL sb_grant_q_rts got=%0h exp=0", q_rts); end
        tick();
        checks++; if (q_rts !== 1'b1 || q_sow !== 1'b1 || q_eow !== 1'b1 || req_rtr !== 4'b0100) begin errors++; $display("FAIL sb_locked got rts=%0h sow=%0h eow=%0h rtr=%0h exp 1 1 1 4", q_rts, q_sow, q_eow, req_rtr); end
        tick();
        clr_req(2);
        #1;
        checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000) begin errors++; $display("FAIL sb_idle got rts=%0h rtr=%0h exp 0 0", q_rts, req_rtr); end
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_rts !== 1'b1 || out_id !== 2'd2) begin errors++; $display("FAIL sb_result got rts=%0h id=%0d exp rts=1 id=2", out_rts, out_id); end
        tick();
        checks++; if (out_rts !== 1'b0) begin errors++; $display("FAIL sb_fifo_empty got=%0h exp=0", out_rts); end
        res_rts = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sb_err got=%0h exp=0", err); end
    endtask

    task automatic test_fifo_full();
        logic [1:0] exp_ids [4];
        exp_ids = '{2'd1, 2'd2, 2'd3, 2'd0};
        out_rtr = 1'b0; res_rts = 1'b0;
        for (int id = 0; id < 4; id++) begin
            set_req(id, 1'b1, 1'b1, 4'(id));
            tick();
            tick();
            clr_req(id);
        end
        set_req(0, 1'b1, 1'b0, 4'h9);
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL full_nogrant0 got=%0h exp=0", q_rts); end
        tick();
        checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000) begin errors++; $display("FAIL full_nogrant1 got rts=%0h rtr=%0h exp 0 0", q_rts, req_rtr); end
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_rts !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL full_head got rts=%0h id=%0d exp rts=1 id=0", out_rts, out_id); end
        tick();
        out_rtr = 1'b0;
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL full_grant_cycle got=%0h exp=0", q_rts); end
        tick();
        checks++; if (q_rts !== 1'b1 || req_rtr !== 4'b0001) begin errors++; $display("FAIL full_granted got rts=%0h rtr=%0h exp 1 1", q_rts, req_rtr); end
        set_req(0, 1'b0, 1'b1, 4'h9);
        tick();
        clr_req(0);
        out_rtr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (out_rts !== 1'b1 || out_id !== exp_ids[k]) begin errors++; $display("FAIL full_drain%0d got rts=%0h id=%0d exp rts=1 id=%0d", k, out_rts, out_id, exp_ids[k]); end
            tick();
        end
        res_rts = 1'b0;
    endtask

    task automatic test_orphan_result();
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b0;
        #1;
        checks++; if (res_rtr !== 1'b1 || out_rts !== 1'b0) begin errors++; $display("FAIL orphan_drop got rtr=%0h out_rts=%0h exp 1 0", res_rtr, out_rts); end
        tick();
        res_rts = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_err got=%0h exp=1", err); end
        tick();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%0h exp=1", err); end
        rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL orphan_err_clear got=%0h exp=0", err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sow_error();
        set_req(2, 1'b1, 1'b0, 4'h1);
        tick();
        tick();
        set_req(2, 1'b1, 1'b0, 4'h2);
        #1;
        checks++; if (q_rts !== 1'b1 || q_sow !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL sowerr_fwd got rts=%0h sow=%0h err=%0h exp 1 1 0", q_rts, q_sow, err); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sowerr_flag got=%0h exp=1", err); end
        set_req(2, 1'b0, 1'b1, 4'h3);
        tick();
        clr_req(2);
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL sowerr_tag got=%0d exp=2", out_id); end
        tick();
        res_rts = 1'b0;
    endtask

    task automatic test_reset_mid_window();
        pulse_reset();
        set_req(0, 1'b1, 1'b0, 4'h1);
        tick();
        tick();
        set_req(0, 1'b0, 1'b0, 4'h2);
        #1;
        checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL mid_locked got=%0h exp=1", req_rtr); end
        rst_n = 1'b0;
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b0;
        #1;
        checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000 || out_rts !== 1'b0) begin errors++; $display("FAIL mid_reset got q_rts=%0h rtr=%0h out_rts=%0h exp 0 0 0", q_rts, req_rtr, out_rts); end
        tick();
        res_rts = 1'b0;
        clr_req(0);
        rst_n = 1'b1;
        tick();
        set_req(1, 1'b1, 1'b1, 4'h4);
        #1;
        checks++; if (q_rts !== 1'b0) begin errors++; $display("FAIL mid_fresh_grant got=%0h exp=0", q_rts); end
        tick();
        checks++; if (req_rtr !== 4'b0010 || q_frac !== 4'h4) begin errors++; $display("FAIL mid_fresh_locked got rtr=%0h frac=%0h exp 2 4", req_rtr, q_frac); end
        tick();
        clr_req(1);
        res_rts = 1'b1; res_eow = 1'b1; out_rtr = 1'b1;
        #1;
        checks++; if (out_rts !== 1'b1 || out_id !== 2'd1) begin errors++; $display("FAIL mid_fresh_tag got rts=%0h id=%0d exp rts=1 id=1", out_rts, out_id); end
        tick();
        res_rts = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got=%0h exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_window();
        test_round_robin();
        test_single_beat();
        test_fifo_full();
        test_orphan_result();
        test_sow_error();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/quire_window_arbiter.md
QUIRE_WINDOW_ARBITER -- requirements
Module: quire_window_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 4, giving the number of requester streams (power of two, 2..8).
REQ-002 SHALL have parameter ID_W, default 2, giving the width of the requester ID (clog2(NB_REQ)).
REQ-003 SHALL have parameter TAG_DEPTH, default 4, giving the number of owner-tag FIFO entries.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_rts_i / req_rtr_o  in / out  NB_REQ  per-requester ready-to-send / ready-to-receive.
REQ-007 req_sow_i, req_eow_i, req_sign_i, req_zero_i, req_NaR_i  in  NB_REQ each  per-requester beat flags.
REQ-008 req_fraction_i  in  NB_REQ*4  per-requester fraction; req_scale_i  in  NB_REQ*4  per-requester signed scale.
REQ-009 q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o  out  1 each; q_rtr_i  in  1: beat to the quire.
REQ-010 q_fraction_o  out  4, q_scale_o  out  4 (signed): beat payload to the quire.
REQ-011 res_rts_i, res_eow_i, res_NaR_i, res_zero_i  in  1 each; res_data_i  in  19; res_rtr_o  out  1: quire result side.
REQ-012 out_rts_o  out  1; out_rtr_i  in  1; out_data_o  out  19; out_id_o  out  ID_W; out_NaR_o, out_zero_o  out  1: tagged window results.
REQ-013 err_o  out  1  sticky protocol-error flag.

Function
REQ-014 The block SHALL share one quire among NB_REQ requesters, granting whole windows (sow beat through eow beat) atomically.
REQ-015 The FSM SHALL have states IDLE and LOCKED; reset state is IDLE.
REQ-016 In IDLE, a requester SHALL be eligible only if req_rts_i and req_sow_i are both high.
- Selection is round-robin starting at rr_ptr.
- A grant SHALL occur only if the tag FIFO is not full.
REQ-017 On a grant, the block SHALL register owner = the winner, push owner into the tag FIFO, and enter LOCKED next cycle.
- No beat is forwarded in the grant cycle; arbitration latency is 1 cycle.
REQ-018 In LOCKED, the owner's beat SHALL pass through combinationally to the quire.
- q_rts_o = req_rts_i[owner]; req_rtr_o[owner] = q_rtr_i.
- All other req_rtr_o SHALL be 0.
REQ-019 In IDLE, all req_rtr_o and q_rts_o SHALL be 0.
REQ-020 A handshake (q_rts_o & q_rtr_i) carrying q_eow_o=1 SHALL return the FSM to IDLE and set rr_ptr to owner+1 mod NB_REQ.
- This includes a single-beat window (sow=eow=1).
REQ-021 Result beats with res_eow_i=0 SHALL be consumed and dropped: res_rtr_o=1, out_rts_o=0.
REQ-022 Result beats with res_eow_i=1 SHALL pass through to the output side.
- out_rts_o = res_rts_i & tag FIFO not empty; res_rtr_o = out_rtr_i.
- out_id_o SHALL be the tag FIFO head; out_data_o, out_NaR_o and out_zero_o SHALL be taken from res_*.
- The tag FIFO SHALL pop on the out_rts_o & out_rtr_i handshake.
REQ-023 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged; pointers SHALL wrap modulo TAG_DEPTH.
REQ-024 An eow result arriving with the tag FIFO empty SHALL be dropped (res_rtr_o=1) and SHALL set err_o.
REQ-025 A beat in LOCKED carrying q_sow_o=1 after the window's first beat SHALL set err_o; the beat is still forwarded.
REQ-026 err_o SHALL clear only on reset.

Reset
REQ-027 While rst_n=0, the block SHALL hold state IDLE, rr_ptr=0, owner=0, tag FIFO empty, err_o=0.
REQ-028 While rst_n=0, all *_rts_o and req_rtr_o outputs SHALL be 0.
REQ-029 Reset mid-window SHALL discard the window and all outstanding tags; no recovery handshake is required.

Structure
REQ-030 The quire beat struct (fraction, scale, sign, zero, NaR, sow, eow) and QUIRE_SIZE=19 SHALL live in posit_defines.
REQ-031 The tag FIFO SHALL be a sub-module named tag_fifo, parameterised by depth and width, providing full/empty flags.

Verification
REQ-032 Req0 sends a 3-beat window (sow..eow), others idle -> grant 1 cycle later, 3 beats forwarded in order, rr_ptr=1, one result with out_id_o=0.
REQ-033 Req1 and req3 both hold sow at rr_ptr=2 -> req3 granted first; req1 granted on the cycle after req3's eow handshake; results tagged 3 then 1.
REQ-034 Req2 sends a single beat with sow=eow=1 -> FSM goes IDLE->LOCKED->IDLE; exactly one tag is pushed and popped.
REQ-035 Hold out_rtr_i=0 with 4 windows outstanding -> tag FIFO full, a 5th sow request is not granted until one result is popped.
REQ-036 Inject res_eow_i=1 with the tag FIFO empty -> beat dropped, err_o=1, and err_o stays high until rst_n pulse.
REQ-037 Assert rst_n=0 mid-window of req0 -> next cycle all rts/rtr outputs are 0, FIFO empty, and a fresh req1 window is granted normally after release.
